// File: rtl/prbs_link_checker.sv
// PRBS7 built-in self-test for the FSK/Hamming link: drives a PRBS word stream
// into the encoder and checks the decoded stream against a regenerated copy.
module prbs_link_checker #(
    parameter int         DATA_WIDTH  = 4,
    parameter logic [6:0] SEED        = 7'h7F,
    parameter int         NUM_WORDS   = 64,
    parameter int         COUNT_WIDTH = 16,
    parameter int         TIMEOUT     = 4096
) (
    input  logic                   sys_clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   rx_valid,
    input  logic [DATA_WIDTH-1:0]  rx_data,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] rx_word_count,
    output logic [COUNT_WIDTH-1:0] err_word_count,
    output logic [COUNT_WIDTH-1:0] err_bit_count
);
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    localparam int TXC_W  = $clog2(NUM_WORDS + 1);
    localparam int SUM_W  = COUNT_WIDTH + 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] NW_CNT   = COUNT_WIDTH'(NUM_WORDS);
    localparam logic [TXC_W-1:0]       TX_LAST  = TXC_W'(NUM_WORDS - 1);
    localparam logic [IDLE_W-1:0]      IDLE_MAX = '1;
    localparam logic [IDLE_W-1:0]      IDLE_LIM = IDLE_W'(TIMEOUT);

    // Runs DATA_WIDTH LFSR steps; returns {word (first bit in MSB), next state}.
    function automatic logic [DATA_WIDTH+6:0] prbs_word(input logic [6:0] s_in);
        logic [6:0]            s;
        logic [DATA_WIDTH-1:0] w;
        logic                  nb;
        s = s_in;
        w = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            nb   = s[6] ^ s[5];
            s    = {s[5:0], nb};
            w[i] = nb;
        end
        return {w, s};
    endfunction

    logic [1:0]             state_q, state_d;
    logic [6:0]             gen_lfsr_q, gen_lfsr_d, chk_lfsr_q, chk_lfsr_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [TXC_W-1:0]       tx_cnt_q, tx_cnt_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic [COUNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d, err_word_q, err_word_d, err_bit_q, err_bit_d;
    logic                   timeout_q, timeout_d, overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]  seed_word, gen_word, exp_word, mism;
    logic [6:0]             seed_next, gen_next, chk_next;
    logic [4:0]             popcnt;
    logic [SUM_W-1:0]       bit_sum;

    always_comb begin
        {seed_word, seed_next} = prbs_word(SEED);
        {gen_word, gen_next}   = prbs_word(gen_lfsr_q);
        {exp_word, chk_next}   = prbs_word(chk_lfsr_q);
        mism   = rx_data ^ exp_word;
        popcnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) popcnt = popcnt + 5'(mism[i]);
        bit_sum = SUM_W'(err_bit_q) + SUM_W'(popcnt);
    end

    always_comb begin
        state_d    = state_q;
        gen_lfsr_d = gen_lfsr_q;
        chk_lfsr_d = chk_lfsr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_cnt_d   = tx_cnt_q;
        idle_d     = '0;
        rx_cnt_d   = rx_cnt_q;
        err_word_d = err_word_q;
        err_bit_d  = err_bit_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Word 0 is preloaded so tx_valid can rise on the first RUN cycle.
                if (start) begin
                    state_d    = S_RUN;
                    tx_valid_d = 1'b1;
                    tx_data_d  = seed_word;
                    gen_lfsr_d = seed_next;
                    chk_lfsr_d = SEED;
                    tx_cnt_d   = '0;
                    rx_cnt_d   = '0;
                    err_word_d = '0;
                    err_bit_d  = '0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            S_RUN: begin
                if (tx_valid_q && tx_ready) begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == TX_LAST) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_DRAIN;
                    end else begin
                        tx_data_d  = gen_word;
                        gen_lfsr_d = gen_next;
                    end
                end
            end
            default: begin
                idle_d = rx_valid ? '0 : (idle_q == IDLE_MAX ? idle_q : idle_q + 1'b1);
                if (rx_cnt_q == NW_CNT) begin
                    state_d = S_DONE;
                end else if (idle_d >= IDLE_LIM) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
        endcase

        // The checker runs independently of the transmit side.
        if ((state_q == S_RUN || state_q == S_DRAIN) && rx_valid) begin
            if (rx_cnt_q < NW_CNT) begin
                rx_cnt_d   = (rx_cnt_q == CNT_MAX) ? rx_cnt_q : rx_cnt_q + 1'b1;
                chk_lfsr_d = chk_next;
                if (mism != '0 && err_word_q != CNT_MAX) err_word_d = err_word_q + 1'b1;
                err_bit_d  = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[COUNT_WIDTH-1:0];
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gen_lfsr_q <= SEED;
            chk_lfsr_q <= SEED;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_cnt_q   <= '0;
            idle_q     <= '0;
            rx_cnt_q   <= '0;
            err_word_q <= '0;
            err_bit_q  <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_lfsr_q <= gen_lfsr_d;
            chk_lfsr_q <= chk_lfsr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_cnt_q   <= tx_cnt_d;
            idle_q     <= idle_d;
            rx_cnt_q   <= rx_cnt_d;
            err_word_q <= err_word_d;
            err_bit_q  <= err_bit_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_valid       = tx_valid_q;
    assign tx_data        = tx_data_q;
    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign timeout        = timeout_q;
    assign overflow       = overflow_q;
    assign rx_word_count  = rx_cnt_q;
    assign err_word_count = err_word_q;
    assign err_bit_count  = err_bit_q;
endmodule

// File: tb/tb_prbs_link_checker.sv
// Directed bench for prbs_link_checker: a 3-cycle loopback link model with
// optional corruption, drops, extra words, backpressure and mid-run reset.
module tb_prbs_link_checker;
    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        tx_ready  = 1'b0;
    logic        rx_valid  = 1'b0;
    logic [3:0]  rx_data   = '0;
    logic        tx_valid, busy, done, timeout, overflow;
    logic [3:0]  tx_data;
    logic [15:0] rx_word_count, err_word_count, err_bit_count;

    prbs_link_checker #(
        .DATA_WIDTH(4), .SEED(7'h7F), .NUM_WORDS(64), .COUNT_WIDTH(16), .TIMEOUT(100)
    ) dut (
        .sys_clock(sys_clock), .reset(reset), .start(start),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
        .rx_word_count(rx_word_count), .err_word_count(err_word_count),
        .err_bit_count(err_bit_count)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [3:0] data;
        int         idx;
        int         due;
    } pkt_t;

    pkt_t       q[$];
    logic [3:0] exp_words[64];
    logic [3:0] first_w[2];
    int checks = 0, failures = 0;
    int hs, extra_hs, tx_bad, stab_bad, cyc, last_rx_cyc, done_cyc, first_hs_cyc, last_hs_cyc;
    logic busy_mid;

    function automatic void gen_expected();
        logic [6:0] s;
        logic [3:0] w;
        logic       nb;
        s = 7'h7F;
        w = '0;
        for (int k = 0; k < 64; k++) begin
            for (int b = 3; b >= 0; b--) begin
                nb   = s[6] ^ s[5];
                s    = {s[5:0], nb};
                w[b] = nb;
            end
            exp_words[k] = w;
        end
    endfunction

    function automatic logic [3:0] corrupt(input int k, input int mode);
        if (mode == 1 && (k == 5 || k == 9)) return 4'h1;
        if (mode == 1 && k == 20) return 4'hF;
        return 4'h0;
    endfunction

    // Pulses start, then runs the link one cycle per negedge until done, a
    // cycle budget, or (when reset_at > 0) reset is raised after reset_at handshakes.
    task automatic run_link(input int drop_last, input int err_mode, input bit rand_ready,
                            input int reset_at, input bit extra_rx);
        pkt_t       p;
        bit         held;
        logic [3:0] held_w;
        int         extra_cyc;
        q.delete();
        hs = 0; extra_hs = 0; tx_bad = 0; stab_bad = 0; cyc = 0;
        last_rx_cyc = -1; done_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
        extra_cyc = -1; held = 0; held_w = '0; busy_mid = 1'b0;
        first_w[0] = 4'hx; first_w[1] = 4'hx;
        start = 1'b1;
        @(negedge sys_clock);
        start = 1'b0;
        while (!done && cyc < 1000) begin
            if (cyc == 10) busy_mid = busy;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held && tx_data !== held_w) stab_bad++;
            held = 0;
            if (tx_valid && tx_ready) begin
                if (hs < 64) begin
                    if (tx_data !== exp_words[hs]) tx_bad++;
                    if (hs < 2) first_w[hs] = tx_data;
                end else begin
                    extra_hs++;
                end
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                p.data = tx_data ^ corrupt(hs, err_mode);
                p.idx  = hs;
                p.due  = cyc + 3;
                q.push_back(p);
                hs++;
            end else if (tx_valid) begin
                held   = 1;
                held_w = tx_data;
            end
            rx_valid = 1'b0;
            rx_data  = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                p = q.pop_front();
                if (p.idx < 64 - drop_last) begin
                    rx_valid    = 1'b1;
                    rx_data     = p.data;
                    last_rx_cyc = cyc;
                    if (p.idx == 63 && extra_rx) extra_cyc = cyc + 1;
                end
            end else if (cyc == extra_cyc) begin
                rx_valid = 1'b1;
                rx_data  = 4'hF;
            end
            if (reset_at > 0 && hs >= reset_at) begin
                reset    = 1'b1;
                rx_valid = 1'b0;
                break;
            end
            @(negedge sys_clock);
            cyc++;
        end
        if (done) done_cyc = cyc;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sys_clock);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 4'h0) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
        checks++; if ({busy, done, timeout, overflow} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, timeout, overflow}); end
        checks++; if ({rx_word_count, err_word_count, err_bit_count} !== 48'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", rx_word_count, err_word_count, err_bit_count); end
        reset = 1'b0;
        rx_valid = 1'b1; rx_data = 4'h5;
        @(negedge sys_clock);
        rx_valid = 1'b0;
        @(negedge sys_clock);
        checks++; if (rx_word_count !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL idle_rx_ignored got cnt=%0d busy=%0b exp cnt=0 busy=0", rx_word_count, busy); end
    endtask

    task automatic test_clean();
        run_link(0, 0, 0, 0, 0);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL clean_done got=%0b exp=1", done); end
        checks++; if (first_w[0] !== 4'h0 || first_w[1] !== 4'h2) begin failures++; $display("FAIL clean_first_words got=%0h,%0h exp=0,2", first_w[0], first_w[1]); end
        checks++; if (tx_bad !== 0) begin failures++; $display("FAIL clean_tx_seq got=%0d bad exp=0", tx_bad); end
        checks++; if (hs !== 64 || first_hs_cyc !== 0 || last_hs_cyc !== 63) begin failures++; $display("FAIL clean_no_bubbles got hs=%0d first=%0d last=%0d exp 64/0/63", hs, first_hs_cyc, last_hs_cyc); end
        checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL clean_busy got=%0b exp=1", busy_mid); end
        checks++; if (rx_word_count !== 16'd64) begin failures++; $display("FAIL clean_rx_count got=%0d exp=64", rx_word_count); end
        checks++; if (err_word_count !== 16'd0 || err_bit_count !== 16'd0) begin failures++; $display("FAIL clean_errors got=%0d/%0d exp=0/0", err_word_count, err_bit_count); end
        checks++; if (timeout !== 1'b0 || overflow !== 1'b0 || tx_valid !== 1'b0) begin failures++; $display("FAIL clean_flags got to=%0b ov=%0b txv=%0b exp 0/0/0", timeout, overflow, tx_valid); end
    endtask

    task automatic test_errors();
        run_link(0, 1, 0, 0, 0);
        checks++; if (done !== 1'b1 || rx_word_count !== 16'd64) begin failures++; $display("FAIL err_done got done=%0b cnt=%0d exp 1/64", done, rx_word_count); end
        checks++; if (err_word_count !== 16'd3) begin failures++; $display("FAIL err_word_count got=%0d exp=3", err_word_count); end
        checks++; if (err_bit_count !== 16'd6) begin failures++; $display("FAIL err_bit_count got=%0d exp=6", err_bit_count); end
    endtask

    task automatic test_backpressure();
        run_link(0, 0, 1, 0, 0);
        checks++; if (stab_bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", stab_bad); end
        checks++; if (hs !== 64 || extra_hs !== 0 || tx_bad !== 0) begin failures++; $display("FAIL bp_handshakes got hs=%0d extra=%0d bad=%0d exp 64/0/0", hs, extra_hs, tx_bad); end
        checks++; if (done !== 1'b1 || rx_word_count !== 16'd64 || err_word_count !== 16'd0 || err_bit_count !== 16'd0 || timeout !== 1'b0) begin
            failures++; $display("FAIL bp_results got done=%0b cnt=%0d ew=%0d eb=%0d to=%0b exp 1/64/0/0/0", done, rx_word_count, err_word_count, err_bit_count, timeout);
        end
    endtask

    task automatic test_timeout();
        run_link(2, 0, 0, 0, 0);
        checks++; if (done !== 1'b1 || timeout !== 1'b1) begin failures++; $display("FAIL to_flags got done=%0b to=%0b exp 1/1", done, timeout); end
        checks++; if (rx_word_count !== 16'd62) begin failures++; $display("FAIL to_rx_count got=%0d exp=62", rx_word_count); end
        checks++; if (done_cyc - last_rx_cyc - 1 !== 100) begin failures++; $display("FAIL to_latency got=%0d exp=100", done_cyc - last_rx_cyc - 1); end
    endtask

    task automatic test_overflow();
        run_link(0, 0, 0, 0, 1);
        checks++; if (overflow !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL ov_flag got ov=%0b done=%0b exp 1/1", overflow, done); end
        checks++; if (rx_word_count !== 16'd64 || err_word_count !== 16'd0 || err_bit_count !== 16'd0) begin
            failures++; $display("FAIL ov_counts got=%0d/%0d/%0d exp 64/0/0", rx_word_count, err_word_count, err_bit_count);
        end
    endtask

    task automatic test_reset_midrun();
        run_link(0, 0, 0, 30, 0);
        @(negedge sys_clock);
        checks++; if (tx_valid !== 1'b0 || tx_data !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL mid_reset_outputs got txv=%0b txd=%0h busy=%0b done=%0b exp 0/0/0/0", tx_valid, tx_data, busy, done);
        end
        checks++; if (rx_word_count !== 16'd0 || err_word_count !== 16'd0 || err_bit_count !== 16'd0) begin
            failures++; $display("FAIL mid_reset_counts got=%0d/%0d/%0d exp 0/0/0", rx_word_count, err_word_count, err_bit_count);
        end
        reset = 1'b0;
        @(negedge sys_clock);
        run_link(0, 0, 0, 0, 0);
        checks++; if (first_w[0] !== 4'h0 || tx_bad !== 0) begin failures++; $display("FAIL mid_restart_seq got first=%0h bad=%0d exp 0/0", first_w[0], tx_bad); end
        checks++; if (done !== 1'b1 || rx_word_count !== 16'd64 || err_word_count !== 16'd0 || err_bit_count !== 16'd0) begin
            failures++; $display("FAIL mid_restart_results got done=%0b cnt=%0d ew=%0d eb=%0d exp 1/64/0/0", done, rx_word_count, err_word_count, err_bit_count);
        end
    endtask

    initial begin
        gen_expected();
        test_reset();
        test_clean();
        test_errors();
        test_backpressure();
        test_timeout();
        test_overflow();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prbs_link_checker.md
Name: prbs_link_checker

Overview:
Synthesizable built-in self-test block for the FSK/Hamming link. It generates a PRBS7 data stream of DATA_WIDTH-bit words toward the transmit side and regenerates the same sequence on the receive side. Received words are compared in order, and the block counts word and bit errors.
- Replaces manual waveform inspection of the link output.
- Sits between the system controller and the encoder input / decoder output.

Parameters:
DATA_WIDTH, 4, bits per transmitted word (1..16).
SEED, 7'h7F, PRBS7 initial LFSR state (must be non-zero).
NUM_WORDS, 64, words sent per test run (≥1).
COUNT_WIDTH, 16, width of all counters.
TIMEOUT, 4096, max idle cycles in DRAIN with no rx_valid before abort.

Ports:
sys_clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
tx_valid  out  1  tx_data holds a valid word.
tx_ready  in  1  downstream accepts the word when tx_valid&tx_ready.
tx_data  out  DATA_WIDTH  generated PRBS word.
rx_valid  in  1  rx_data valid this cycle.
rx_data  in  DATA_WIDTH  decoded word from link.
busy  out  1  high in RUN or DRAIN.
done  out  1  high in DONE.
timeout  out  1  run ended by TIMEOUT; valid while done.
overflow  out  1  rx_valid seen after NUM_WORDS words were received.
rx_word_count  out  COUNT_WIDTH  words received this run.
err_word_count  out  COUNT_WIDTH  received words with ≥1 bit mismatch.
err_bit_count  out  COUNT_WIDTH  total mismatched bits.

Behaviour:
- Reset (synchronous, any state, mid-run included):
  - State goes to IDLE.
  - All outputs and counters = 0, tx_data = 0.
  - Both LFSRs = SEED.
- PRBS step (shared by generator and checker):
  - new = s[6]^s[5]; s <= {s[5:0], new}; output bit = new.
  - One word = DATA_WIDTH consecutive steps, first bit in the MSB.
  - SEED 7'h7F with DATA_WIDTH=4 gives words 4'h0, 4'h2, ...
- States:
  - IDLE:
    - start → RUN.
    - All counters, flags and both LFSRs are reloaded to 0/SEED on the same edge.
  - RUN:
    - tx_valid=1 from the first cycle after entry.
    - tx_data holds word k until the handshake, then advances to word k+1 on the next cycle; 0 bubbles required.
    - tx_data must stay stable while tx_valid&!tx_ready.
    - After the NUM_WORDS-th handshake: tx_valid=0 next cycle, state → DRAIN.
  - DRAIN:
    - Idle counter increments each cycle without rx_valid and clears on rx_valid.
    - rx_word_count==NUM_WORDS → DONE.
    - Idle counter reaching TIMEOUT → DONE with timeout=1.
  - DONE:
    - done=1; counters hold.
    - start → RUN, clearing counters, flags and LFSRs on the same edge.
- Checker:
  - Active in RUN and DRAIN only; rx_valid in IDLE/DONE is ignored.
  - On rx_valid with rx_word_count<NUM_WORDS:
    - Compare rx_data with expected word k.
    - err_bit_count += popcount(rx_data ^ expected).
    - err_word_count += (mismatch != 0).
    - rx_word_count++, advance checker LFSR.
  - Counter updates are visible the cycle after rx_valid.
  - rx_valid while rx_word_count==NUM_WORDS: set overflow (sticky per run); counters unchanged.
  - rx_valid during RUN is legal (pipelined link), including in the same cycle as a tx handshake; both are processed independently.
  - The checker never depends on tx state; link latency is arbitrary but order-preserving.
- Arithmetic and counter rules:
  - All counters saturate at 2^COUNT_WIDTH-1, never wrap.
  - The timeout idle counter is log2(TIMEOUT)+1 bits and saturates.
- start pulses in RUN or DRAIN are ignored.

Test Plan:
- Loopback (rx = tx delayed 3 cycles), DATA_WIDTH=4, NUM_WORDS=64 → first tx words 4'h0, 4'h2; done after last rx; rx_word_count=64, err_word_count=0, err_bit_count=0, timeout=0.
- Loopback with rx_data bit 0 inverted on words 5 and 9, plus 4'hF XOR on word 20 → err_word_count=3, err_bit_count=6.
- tx_ready random 50% → tx_data stable under backpressure; exactly 64 handshakes; results identical to the clean loopback case.
- Link drops the last 2 words, TIMEOUT=100 → DONE reached 100 cycles after the last rx; timeout=1, rx_word_count=62.
- Extra rx_valid after word 64 → overflow=1, counts unchanged.
- Reset asserted mid-RUN at word 30, then start → outputs 0 in the cycle after reset; the new run begins again at word 4'h0; clean loopback passes.
